// File: rtl/seq_detect_arbiter_if.sv
// rtl/seq_detect_arbiter_if.sv - request/grant/result bundle for the run-detecting arbiter
interface seq_detect_arbiter_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          req0;
    logic [W-1:0]  data0;
    logic          req1;
    logic [W-1:0]  data1;
    logic          gnt0;
    logic          gnt1;
    logic          busy;
    logic          done;
    logic          done_id;
    logic [CW-1:0] match_cnt;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, busy, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - two-way round-robin arbiter feeding an MSB-first run-of-three counter
module seq_detect_arbiter #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_arbiter_if.slave  bus
);
    localparam int BW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  sr;
    logic [BW-1:0] bcnt;
    logic          p1;
    logic          p2;
    logic [CW-1:0] cnt;
    logic          last;

    logic          pick;
    logic          run_bit;
    logic          hit;

    always_comb begin
        pick    = 1'b0;
        run_bit = sr[W-1];
        hit     = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick = ~last;
        end else begin
            pick = bus.req1;
        end
        // p1/p2 only hold real bits once two bits of this word have been shifted
        if ((bcnt >= BW'(2)) && (run_bit == p1) && (p1 == p2)) begin
            hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sr            <= '0;
            bcnt          <= '0;
            p1            <= 1'b0;
            p2            <= 1'b0;
            cnt           <= '0;
            last          <= 1'b1;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_id   <= 1'b0;
            bus.match_cnt <= '0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        sr       <= pick ? bus.data1 : bus.data0;
                        bus.gnt0 <= ~pick;
                        bus.gnt1 <= pick;
                        last     <= pick;
                        bus.busy <= 1'b1;
                        bcnt     <= '0;
                        cnt      <= '0;
                        p1       <= 1'b0;
                        p2       <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // one extra cycle after the last bit lets the final hit land in cnt
                    if (bcnt == BW'(W)) begin
                        bus.done      <= 1'b1;
                        bus.done_id   <= last;
                        bus.match_cnt <= cnt;
                        state         <= REPORT;
                    end else begin
                        sr   <= {sr[W-2:0], 1'b0};
                        p2   <= p1;
                        p1   <= run_bit;
                        bcnt <= bcnt + 1'b1;
                        if (hit) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the width of each request data word (W >= 3).
REQ-002 The block SHALL have parameter CW, default 4, meaning the width of match_cnt; CW SHALL be large enough to hold W-2.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req0  input  1  requester 0 asks for a detection run.
REQ-006 The block SHALL have port data0  input  W  requester 0 word, held stable while req0=1 and gnt0 has not yet been seen.
REQ-007 The block SHALL have port req1  input  1  requester 1 asks for a detection run.
REQ-008 The block SHALL have port data1  input  W  requester 1 word, with the same rule as data0.
REQ-009 The block SHALL have port gnt0  output  1  one-cycle pulse: data0 captured.
REQ-010 The block SHALL have port gnt1  output  1  one-cycle pulse: data1 captured.
REQ-011 The block SHALL have port busy  output  1  high while a run is in progress (from the gnt cycle through the done cycle).
REQ-012 The block SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-013 The block SHALL have port done_id  output  1  requester that owns the current result.
REQ-014 The block SHALL have port match_cnt  output  CW  number of detections in the word.

Function
REQ-015 The block SHALL implement the FSM states IDLE, SHIFT and REPORT.
REQ-016 In IDLE, if req0 or req1 is high at a clock edge, the block SHALL capture the selected word, enter SHIFT, and drive the matching gnt high for exactly the following cycle (cycle C).
REQ-017 Arbitration SHALL be round-robin on simultaneous requests: grant the requester not granted last; a lone request SHALL be granted regardless of history.
REQ-018 The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 Requests arriving in SHIFT or REPORT SHALL be ignored (not queued) until the FSM returns to IDLE.
REQ-020 In SHIFT, the captured word SHALL be serialized MSB first, one bit per cycle, for exactly W cycles.
REQ-021 Serialized bits SHALL feed an internal run detector that is cleared at the start of every word, so no history carries across words.
REQ-022 The detector SHALL flag bit position k (1..W) when k >= 3 and bits k-2, k-1 and k are all 0 or all 1; runs longer than 3 SHALL flag every further position.
REQ-023 match_cnt SHALL equal the number of flagged positions in the word, range 0..W-2.
REQ-024 done SHALL be high only in cycle C+W+1; done_id and match_cnt SHALL be valid in that cycle.
REQ-025 After REPORT the FSM SHALL return to IDLE; the earliest next gnt SHALL be cycle C+W+3.
REQ-026 match_cnt and done_id SHALL hold their values until the next done.
REQ-027 gnt0 and gnt1 SHALL never be high together, and SHALL never be high while a run is in progress.
REQ-028 Changes on data0 or data1 after capture SHALL NOT affect the result.

Reset
REQ-029 When rst=0, the block SHALL asynchronously force: state IDLE; gnt0, gnt1, busy and done = 0; done_id = 0; match_cnt = 0; last-grant pointer = 1; shift register, bit counter and detector state cleared.
REQ-030 Reset asserted mid-run SHALL abort the run, with no done pulse for the aborted word.
REQ-031 The first grant after reset release SHALL occur only from IDLE, on an edge where rst=1.

Verification
REQ-032 Scenario: W=8, req0 with data0=8'b00010111 -> gnt0 in cycle C; done in cycle C+9; done_id=0; match_cnt=2.
REQ-033 Scenario: words 8'h00, 8'hFF and 8'b10101010, one per run -> match_cnt = 6, 6 and 0 respectively.
REQ-034 Scenario: req0 and req1 both asserted and held from reset release -> grant order gnt0, gnt1, gnt0, gnt1; each next gnt exactly W+3 cycles after the previous; done_id alternates 0, 1, 0, 1.
REQ-035 Scenario: rst pulsed low during cycle C+4 of a run -> all outputs 0 immediately; no done appears; a subsequent req1 with 8'hFF completes with match_cnt=6.
REQ-036 Scenario: data0 changed to 8'hAA in cycle C+1 after gnt0 on 8'h00 -> match_cnt=6.
REQ-037 Scenario: req1 pulsed only during a busy period and dropped before IDLE -> no gnt1 and no done for requester 1.
